// File: rtl/io_request_arbiter.sv
// Round-robin arbiter that funnels per-core non-cacheable IO requests onto one device port,
// one transaction in flight. Define IO_ARB_TIMEOUT_EN to build the WAIT-state timeout.
module io_request_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int ID_W          = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQUESTERS-1:0]            req_valid,
    input  logic [NUM_REQUESTERS-1:0]            req_store,
    input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_write_data,
    output logic [NUM_REQUESTERS-1:0]            req_ready,
    output logic                                 rsp_valid,
    output logic [ID_W-1:0]                      rsp_id,
    output logic                                 rsp_store,
    output logic [DATA_WIDTH-1:0]                rsp_read_data,
    output logic                                 rsp_error,
    output logic                                 io_write_en,
    output logic                                 io_read_en,
    output logic [ADDR_WIDTH-1:0]                io_address,
    output logic [DATA_WIDTH-1:0]                io_write_data,
    input  logic [DATA_WIDTH-1:0]                io_read_data,
    input  logic                                 io_rsp_valid
);

    localparam int SUM_W = ID_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

    state_e                    r_state;
    state_e                    w_next;
    logic [ID_W-1:0]           r_rr_ptr;
    logic [ID_W-1:0]           r_id;
    logic                      r_store;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic                      r_io_wr;
    logic                      r_io_rd;
    logic                      r_rsp_valid;
    logic [ID_W-1:0]           r_rsp_id;
    logic                      r_rsp_store;
    logic [DATA_WIDTH-1:0]     r_rsp_data;
    logic                      r_rsp_error;

    logic                      w_found;
    logic [SUM_W-1:0]          w_sum;
    logic [ID_W-1:0]           w_sel;
    logic [ID_W-1:0]           w_grant_id;
    logic                      w_grant_store;
    logic [ADDR_WIDTH-1:0]     w_grant_addr;
    logic [DATA_WIDTH-1:0]     w_grant_data;
    logic [NUM_REQUESTERS-1:0] w_onehot;
    logic [NUM_REQUESTERS-1:0] w_req_ready;
    logic                      w_timeout;
    logic                      w_rsp_error;
    logic [DATA_WIDTH-1:0]     w_rsp_data;

`ifdef IO_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    // WAIT-cycle counter; any other state holds it at zero so it restarts on WAIT entry
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Round-robin search upward from the pointer, then the FSM next-state and response payload
    always_comb begin
        w_next        = r_state;
        w_found       = 1'b0;
        w_sum         = '0;
        w_sel         = '0;
        w_grant_id    = '0;
        w_grant_store = 1'b0;
        w_grant_addr  = '0;
        w_grant_data  = '0;
        w_onehot      = '0;
        w_req_ready   = '0;
        w_rsp_error   = 1'b0;
        w_rsp_data    = '0;

        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            w_sum = {1'b0, r_rr_ptr} + SUM_W'(i);
            if (w_sum >= SUM_W'(NUM_REQUESTERS)) begin
                w_sum = w_sum - SUM_W'(NUM_REQUESTERS);
            end else begin
                w_sum = w_sum;
            end
            w_sel = w_sum[ID_W-1:0];
            if (!w_found && req_valid[w_sel]) begin
                w_found         = 1'b1;
                w_grant_id      = w_sel;
                w_grant_store   = req_store[w_sel];
                w_grant_addr    = req_address[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
                w_grant_data    = req_write_data[w_sel*DATA_WIDTH +: DATA_WIDTH];
                w_onehot[w_sel] = 1'b1;
            end else begin
                w_found = w_found;
            end
        end

        case (r_state)
            ST_IDLE: begin
                // Reset gates the strobe so nothing is consumed while the block is held in reset
                if (w_found && reset) begin
                    w_req_ready = w_onehot;
                    w_next      = ST_ISSUE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (io_rsp_valid) begin
                    w_next     = ST_RESPOND;
                    w_rsp_data = r_store ? {DATA_WIDTH{1'b0}} : io_read_data;
                end else if (w_timeout) begin
                    w_next      = ST_RESPOND;
                    w_rsp_error = 1'b1;
                    w_rsp_data  = {DATA_WIDTH{1'b1}};
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_RESPOND: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State, latched transaction and registered device/response outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_store     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_io_wr     <= 1'b0;
            r_io_rd     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_store <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_ISSUE) begin
                r_id    <= w_grant_id;
                r_store <= w_grant_store;
                r_addr  <= w_grant_addr;
                r_wdata <= w_grant_data;
            end
            r_io_wr     <= (w_next == ST_ISSUE) && w_grant_store;
            r_io_rd     <= (w_next == ST_ISSUE) && !w_grant_store;
            r_rsp_valid <= (w_next == ST_RESPOND);
            r_rsp_id    <= (w_next == ST_RESPOND) ? r_id : {ID_W{1'b0}};
            r_rsp_store <= (w_next == ST_RESPOND) && r_store;
            r_rsp_data  <= w_rsp_data;
            r_rsp_error <= w_rsp_error;
            // Fairness: the core just served drops to lowest priority
            if (r_state == ST_RESPOND) begin
                r_rr_ptr <= (r_id == ID_W'(NUM_REQUESTERS - 1)) ? {ID_W{1'b0}} : r_id + ID_W'(1);
            end
        end
    end

    assign req_ready     = w_req_ready;
    assign io_write_en   = r_io_wr;
    assign io_read_en    = r_io_rd;
    assign io_address    = r_addr;
    assign io_write_data = r_wdata;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_store     = r_rsp_store;
    assign rsp_read_data = r_rsp_data;
    assign rsp_error     = r_rsp_error;

endmodule

// File: tb/tb_io_request_arbiter.sv
// Directed bench for io_request_arbiter: expected responses queued at grant, checked on rsp_valid.
module tb_io_request_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_store;
    logic [N*AW-1:0] req_address;
    logic [N*DW-1:0] req_write_data;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic            rsp_store;
    logic [DW-1:0]   rsp_read_data;
    logic            rsp_error;
    logic            io_write_en;
    logic            io_read_en;
    logic [AW-1:0]   io_address;
    logic [DW-1:0]   io_write_data;
    logic [DW-1:0]   io_read_data;
    logic            io_rsp_valid;

    typedef struct {
        logic [1:0]    id;
        logic          store;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   vecs;
    int   miss;

    io_request_arbiter #(
        .NUM_REQUESTERS(N),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_store     (req_store),
        .req_address   (req_address),
        .req_write_data(req_write_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_store     (rsp_store),
        .rsp_read_data (rsp_read_data),
        .rsp_error     (rsp_error),
        .io_write_en   (io_write_en),
        .io_read_en    (io_read_en),
        .io_address    (io_address),
        .io_write_data (io_write_data),
        .io_read_data  (io_read_data),
        .io_rsp_valid  (io_rsp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_req(input int c, input logic st, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[c]                = 1'b1;
        req_store[c]                = st;
        req_address[c*AW +: AW]     = a;
        req_write_data[c*DW +: DW]  = d;
    endtask

    task automatic push_exp(input int id, input logic st, input logic [DW-1:0] d, input logic e);
        exp_t x;
        x.id    = 2'(id);
        x.store = st;
        x.data  = d;
        x.err   = e;
        sb.push_back(x);
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(e.id));
            chk({tag, "_rsp_store"}, 64'(rsp_store), 64'(e.store));
            chk({tag, "_rsp_data"}, 64'(rsp_read_data), 64'(e.data));
            chk({tag, "_rsp_error"}, 64'(rsp_error), 64'(e.err));
        end
    endtask

    initial begin
        int          order [6];
        int          n;
        int          seen;
        logic [N-1:0] oh;

        order = '{0, 1, 3, 0, 1, 3};
        vecs = 0;
        miss = 0;
        reset = 1'b0;
        req_valid = '0;
        req_store = '0;
        req_address = '0;
        req_write_data = '0;
        io_read_data = '0;
        io_rsp_valid = 1'b0;

        // Reset: outputs zero, and no grant even with a request pending
        cyc();
        cyc();
        req_valid = 4'b0001;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_bundle", 64'({rsp_valid, rsp_id, rsp_store, rsp_error, rsp_read_data}), 64'd0);
        chk("rst_io_bundle", 64'({io_write_en, io_read_en, io_address}), 64'd0);
        cyc();
        reset = 1'b1;
        req_valid = '0;

        // Single read from core 2, device answers two cycles after io_read_en
        cyc();
        set_req(2, 1'b0, 32'hFFFF0004, 32'h0);
        #1;
        chk("t1_ready", 64'(req_ready), 64'b0100);
        push_exp(2, 1'b0, 32'h12345678, 1'b0);
        cyc();
        req_valid = '0;
        #1;
        chk("t1_io_en", 64'({io_write_en, io_read_en}), 64'b01);
        chk("t1_io_addr", 64'(io_address), 64'hFFFF0004);
        chk("t1_ready_pulse", 64'(req_ready), 64'd0);
        cyc();
        #1;
        chk("t1_rd_pulse", 64'(io_read_en), 64'd0);
        cyc();
        io_rsp_valid = 1'b1;
        io_read_data = 32'h12345678;
        #1;
        chk("t1_no_early_rsp", 64'(rsp_valid), 64'd0);
        cyc();
        io_rsp_valid = 1'b0;
        io_read_data = '0;
        #1;
        check_rsp("t1");

        // Write from core 1; device garbage on the read bus must not leak into the response
        cyc();
        set_req(1, 1'b1, 32'hFFFF0010, 32'hA5A5A5A5);
        #1;
        chk("t2_ready", 64'(req_ready), 64'b0010);
        push_exp(1, 1'b1, 32'h0, 1'b0);
        cyc();
        req_valid = '0;
        #1;
        chk("t2_io_en", 64'({io_write_en, io_read_en}), 64'b10);
        chk("t2_io_addr", 64'(io_address), 64'hFFFF0010);
        chk("t2_io_wdata", 64'(io_write_data), 64'hA5A5A5A5);
        cyc();
        io_rsp_valid = 1'b1;
        io_read_data = 32'hDEADBEEF;
        #1;
        chk("t2_wr_pulse", 64'(io_write_en), 64'd0);
        cyc();
        io_rsp_valid = 1'b0;
        #1;
        check_rsp("t2");
        chk("t2_addr_hold", 64'(io_address), 64'hFFFF0010);

        // Stray device ack while idle is ignored
        cyc();
        io_rsp_valid = 1'b1;
        io_read_data = 32'h55555555;
        #1;
        chk("stray_ready", 64'(req_ready), 64'd0);
        cyc();
        io_rsp_valid = 1'b0;
        #1;
        chk("stray_rsp", 64'(rsp_valid), 64'd0);
        chk("stray_io_en", 64'({io_write_en, io_read_en}), 64'd0);

        // Reset during WAIT drops the transaction; late completion is ignored
        cyc();
        set_req(3, 1'b0, 32'h000000C0, 32'h0);
        #1;
        chk("t4_ready", 64'(req_ready), 64'b1000);
        cyc();
        req_valid = '0;
        #1;
        chk("t4_rd_en", 64'(io_read_en), 64'd1);
        cyc();
        reset = 1'b0;
        #1;
        cyc();
        reset = 1'b1;
        io_rsp_valid = 1'b1;
        io_read_data = 32'h77777777;
        #1;
        chk("t4_rsp_zero", 64'({rsp_valid, rsp_id, rsp_store, rsp_error, rsp_read_data}), 64'd0);
        chk("t4_io_zero", 64'({io_write_en, io_read_en, io_address}), 64'd0);
        cyc();
        io_rsp_valid = 1'b0;
        #1;
        chk("t4_no_rsp", 64'(rsp_valid), 64'd0);

        // Fairness with cores 0,1,3 always requesting, starting from a reset pointer
        cyc();
        set_req(0, 1'b0, 32'h00001000, 32'h0);
        set_req(1, 1'b0, 32'h00001010, 32'h0);
        set_req(3, 1'b1, 32'h00001030, 32'h33333333);
        #1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (req_ready === '0 && n < 20) begin
                cyc();
                #1;
                n++;
            end
            oh = 4'b0001 << order[k];
            chk("fair_grant", 64'(req_ready), 64'(oh));
            push_exp(order[k], order[k] == 3, (order[k] == 3) ? 32'h0 : 32'hC0DE0000 + 32'(k), 1'b0);
            cyc();
            #1;
            chk("fair_io_en", 64'({io_write_en, io_read_en}), (order[k] == 3) ? 64'b10 : 64'b01);
            chk("fair_busy", 64'(req_ready), 64'd0);
            cyc();
            io_rsp_valid = 1'b1;
            io_read_data = 32'hC0DE0000 + 32'(k);
            #1;
            cyc();
            io_rsp_valid = 1'b0;
            #1;
            check_rsp("fair");
        end
        req_valid = '0;

        // Device that never answers
        cyc();
        set_req(0, 1'b0, 32'h00002000, 32'h0);
        #1;
        chk("to_ready", 64'(req_ready), 64'b0001);
        cyc();
        req_valid = '0;
        #1;
`ifdef IO_ARB_TIMEOUT_EN
        push_exp(0, 1'b0, 32'hFFFFFFFF, 1'b1);
        repeat (TO) begin
            cyc();
            #1;
        end
        chk("to_not_early", 64'(rsp_valid), 64'd0);
        cyc();
        #1;
        check_rsp("to");
`else
        seen = 0;
        repeat (1000) begin
            cyc();
            #1;
            if (rsp_valid !== 1'b0 || io_read_en !== 1'b0 || req_ready !== '0) seen++;
        end
        chk("stuck_in_wait", 64'(seen), 64'd0);
        push_exp(0, 1'b0, 32'h0BADF00D, 1'b0);
        cyc();
        io_rsp_valid = 1'b1;
        io_read_data = 32'h0BADF00D;
        #1;
        cyc();
        io_rsp_valid = 1'b0;
        #1;
        check_rsp("late");
`endif

        cyc();
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/io_request_arbiter.md
IO_REQUEST_ARBITER -- requirements
Module: io_request_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 4, number of requesting cores (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, non-cacheable address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, IO data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, WAIT-state limit (used only under IO_ARB_TIMEOUT_EN).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port req_valid  input  NUM_REQUESTERS  per-core request pending.
REQ-008 SHALL have port req_store  input  NUM_REQUESTERS  per-core 1=write, 0=read.
REQ-009 SHALL have port req_address  input  NUM_REQUESTERS*ADDR_WIDTH  per-core address, core i at slice i.
REQ-010 SHALL have port req_write_data  input  NUM_REQUESTERS*DATA_WIDTH  per-core store data.
REQ-011 SHALL have port req_ready  output  NUM_REQUESTERS  one-hot accept strobe.
REQ-012 SHALL have port rsp_valid  output  1  response strobe, broadcast to all cores.
REQ-013 SHALL have port rsp_id  output  clog2(NUM_REQUESTERS), min 1  originating core.
REQ-014 SHALL have port rsp_store  output  1  response is write acknowledge.
REQ-015 SHALL have port rsp_read_data  output  DATA_WIDTH  read data.
REQ-016 SHALL have port rsp_error  output  1  transaction timed out.
REQ-017 SHALL have ports io_write_en, io_read_en  output  1 each; io_address  output  ADDR_WIDTH; io_write_data  output  DATA_WIDTH; io_read_data  input  DATA_WIDTH; io_rsp_valid  input  1  device completion.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, RESPOND; exactly one transaction outstanding.
REQ-019 In IDLE with any req_valid, SHALL grant round-robin: first set bit searching upward from rr_ptr, wrapping NUM_REQUESTERS-1 -> 0.
REQ-020 On grant SHALL pulse req_ready[grant] for that cycle only, latch id/store/address/data, go ISSUE; no grant -> stay IDLE, req_ready all 0.
REQ-021 A request SHALL be consumed only in the cycle its req_ready is high; core holds req_valid and payload stable until then.
REQ-022 In ISSUE SHALL assert io_read_en or io_write_en (per latched store) for exactly one cycle with latched address/data, then go WAIT.
REQ-023 In WAIT SHALL capture io_read_data when io_rsp_valid=1 and go RESPOND; io_rsp_valid outside WAIT SHALL be ignored.
REQ-024 In RESPOND SHALL assert rsp_valid one cycle with rsp_id, rsp_store, rsp_read_data (0 for writes), then set rr_ptr=(grant+1) mod NUM_REQUESTERS and go IDLE.
REQ-025 Latency: accept at T, IO strobe T+1, io_rsp_valid at T+2+k gives rsp_valid at T+3+k; next accept no earlier than the RESPOND cycle +1.
REQ-026 io_address/io_write_data SHALL hold latched values from ISSUE through RESPOND; io enables low in all other states.
REQ-027 NUM_REQUESTERS=1 SHALL work with rr_ptr fixed at 0 and rsp_id 1 bit wide, value 0.

Reset
REQ-028 With reset low at a clock edge SHALL enter IDLE, rr_ptr=0, timeout counter=0, all outputs 0, regardless of state (in-flight transaction dropped, no response).
REQ-029 Device completion arriving after reset release SHALL be ignored (state is IDLE).

Configuration
REQ-030 With IO_ARB_TIMEOUT_EN defined, WAIT SHALL count cycles from 0; on reaching TIMEOUT_CYCLES without io_rsp_valid SHALL go RESPOND with rsp_error=1, rsp_read_data all ones; counter clears on WAIT entry.
REQ-031 Without IO_ARB_TIMEOUT_EN, no counter SHALL be built, WAIT lasts until io_rsp_valid, rsp_error tied 0.

Verification
REQ-032 Single read: core 2 reads 0xFFFF0004, device returns 0x12345678 two cycles after io_read_en -> req_ready[2] at T, io_read_en at T+1, rsp_valid/rsp_id=2/data 0x12345678 at T+4.
REQ-033 Fairness: cores 0,1,3 hold req_valid continuously, devices ack immediately -> grant order 0,1,3,0,1,3; no core granted twice before others.
REQ-034 Write: core 1 stores 0xA5A5A5A5 to 0xFFFF0010 -> io_write_en one cycle with that address/data, rsp_store=1, rsp_read_data=0.
REQ-035 Reset mid-WAIT: reset low one cycle during WAIT, then io_rsp_valid -> no rsp_valid, outputs 0, next request granted from core 0 pointer.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=8): no io_rsp_valid -> rsp_valid with rsp_error=1, data 0xFFFFFFFF after 8 WAIT cycles; macro off -> arbiter stays in WAIT for 1000 cycles.
REQ-037 Stray ack: io_rsp_valid pulsed in IDLE -> no rsp_valid, state unchanged.
